// File: rtl/compare_tally.sv
// Two-stage magnitude comparator: captures operands on load, registers the
// one-hot compare result and display symbol one edge later, and keeps tallies.
module compare_tally #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 load,
    input  logic                 signed_mode,
    input  logic                 clr_cnt,
    output logic [WIDTH-1:0]     a_q,
    output logic [WIDTH-1:0]     b_q,
    output logic                 lt,
    output logic                 gt,
    output logic                 eq,
    output logic [3:0]           sym,
    output logic                 result_valid,
    output logic [CNT_WIDTH-1:0] gt_cnt,
    output logic [CNT_WIDTH-1:0] lt_cnt,
    output logic [CNT_WIDTH-1:0] eq_cnt
);

    localparam logic [3:0] SYM_GT   = 4'hA;
    localparam logic [3:0] SYM_LT   = 4'hB;
    localparam logic [3:0] SYM_EQ   = 4'hE;
    localparam logic [3:0] SYM_NONE = 4'hF;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic             mode_r;
    logic             s1_valid_r;
    logic [WIDTH-1:0] key_a_s;
    logic [WIDTH-1:0] key_b_s;
    logic             lt_s;
    logic             gt_s;
    logic             eq_s;

    function automatic logic [3:0] sym_code(input logic is_gt, input logic is_lt);
        logic [3:0] code;
        case ({is_gt, is_lt})
            2'b10:   code = SYM_GT;
            2'b01:   code = SYM_LT;
            2'b00:   code = SYM_EQ;
            default: code = SYM_NONE;
        endcase
        return code;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                     input logic hit);
        logic [CNT_WIDTH-1:0] next;
        if (hit && (cnt != CNT_MAX)) begin
            next = cnt + CNT_ONE;
        end else begin
            next = cnt;
        end
        return next;
    endfunction

    // Stage 1: capture operands and mode on load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            mode_r     <= 1'b0;
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= load;
            if (load) begin
                a_q    <= a;
                b_q    <= b;
                mode_r <= signed_mode;
            end else begin
                a_q    <= a_q;
                b_q    <= b_q;
                mode_r <= mode_r;
            end
        end
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order
    always_comb begin
        key_a_s = a_q;
        key_b_s = b_q;
        if (mode_r) begin
            key_a_s[WIDTH-1] = ~a_q[WIDTH-1];
            key_b_s[WIDTH-1] = ~b_q[WIDTH-1];
        end else begin
            key_a_s = a_q;
            key_b_s = b_q;
        end
        lt_s = (key_a_s < key_b_s);
        gt_s = (key_a_s > key_b_s);
        eq_s = ~lt_s & ~gt_s;
    end

    // Stage 2: register flags, symbol and the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lt           <= 1'b0;
            gt           <= 1'b0;
            eq           <= 1'b0;
            sym          <= SYM_NONE;
            result_valid <= 1'b0;
        end else if (s1_valid_r) begin
            lt           <= lt_s;
            gt           <= gt_s;
            eq           <= eq_s;
            sym          <= sym_code(gt_s, lt_s);
            result_valid <= 1'b1;
        end else begin
            result_valid <= 1'b0;
        end
    end

    // Saturating tallies; a clear on the same edge discards the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_cnt <= CNT_ZERO;
            lt_cnt <= CNT_ZERO;
            eq_cnt <= CNT_ZERO;
        end else if (clr_cnt) begin
            gt_cnt <= CNT_ZERO;
            lt_cnt <= CNT_ZERO;
            eq_cnt <= CNT_ZERO;
        end else if (s1_valid_r) begin
            gt_cnt <= sat_inc(gt_cnt, gt_s);
            lt_cnt <= sat_inc(lt_cnt, lt_s);
            eq_cnt <= sat_inc(eq_cnt, eq_s);
        end else begin
            gt_cnt <= gt_cnt;
            lt_cnt <= lt_cnt;
            eq_cnt <= eq_cnt;
        end
    end

endmodule

// File: tb/tb_compare_tally.sv
// Bench for compare_tally: a 4-bit/2-bit-tally instance and a 16-bit/8-bit-tally
// instance driven in lockstep and checked against an arithmetic reference model.
module tb_compare_tally;

    logic clk;
    logic rst;

    logic [15:0] in_a    [2];
    logic [15:0] in_b    [2];
    logic        in_load [2];
    logic        in_mode [2];
    logic        in_clr  [2];

    logic [3:0]  aq0, bq0;
    logic        lt0, gt0, eq0, rv0;
    logic [3:0]  sym0;
    logic [1:0]  gc0, lc0, ec0;

    logic [15:0] aq1, bq1;
    logic        lt1, gt1, eq1, rv1;
    logic [3:0]  sym1;
    logic [7:0]  gc1, lc1, ec1;

    logic [3:0]  a0_s, b0_s;
    logic [15:0] a1_s, b1_s;
    logic        ld0_s, ld1_s, md0_s, md1_s, cl0_s, cl1_s;

    assign a0_s  = in_a[0][3:0];
    assign b0_s  = in_b[0][3:0];
    assign a1_s  = in_a[1];
    assign b1_s  = in_b[1];
    assign ld0_s = in_load[0];
    assign ld1_s = in_load[1];
    assign md0_s = in_mode[0];
    assign md1_s = in_mode[1];
    assign cl0_s = in_clr[0];
    assign cl1_s = in_clr[1];

    compare_tally #(.WIDTH(4), .CNT_WIDTH(2)) u_dut0 (
        .clk(clk), .rst(rst), .a(a0_s), .b(b0_s), .load(ld0_s),
        .signed_mode(md0_s), .clr_cnt(cl0_s), .a_q(aq0), .b_q(bq0),
        .lt(lt0), .gt(gt0), .eq(eq0), .sym(sym0), .result_valid(rv0),
        .gt_cnt(gc0), .lt_cnt(lc0), .eq_cnt(ec0)
    );

    compare_tally #(.WIDTH(16), .CNT_WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1_s), .b(b1_s), .load(ld1_s),
        .signed_mode(md1_s), .clr_cnt(cl1_s), .a_q(aq1), .b_q(bq1),
        .lt(lt1), .gt(gt1), .eq(eq1), .sym(sym1), .result_valid(rv1),
        .gt_cnt(gc1), .lt_cnt(lc1), .eq_cnt(ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state, per instance
    int          wdt  [2] = '{4, 16};
    int          cmax [2] = '{3, 255};
    logic [15:0] m_aq [2], m_bq [2], p_a [2], p_b [2];
    int          p_v [2], p_m [2];
    int          m_lt [2], m_gt [2], m_eq [2], m_sym [2], m_rv [2];
    int          m_gc [2], m_lc [2], m_ec [2];

    function automatic int sval(input logic [15:0] v, input int w);
        int u;
        u = int'(v);
        if (u >= (1 << (w - 1))) return u - (1 << w);
        return u;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_aq[i] = 16'h0; m_bq[i] = 16'h0;
            p_a[i] = 16'h0; p_b[i] = 16'h0; p_v[i] = 0; p_m[i] = 0;
            m_lt[i] = 0; m_gt[i] = 0; m_eq[i] = 0; m_sym[i] = 15; m_rv[i] = 0;
            m_gc[i] = 0; m_lc[i] = 0; m_ec[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        int x, y;
        if (p_v[i] != 0) begin
            x = (p_m[i] != 0) ? sval(p_a[i], wdt[i]) : int'(p_a[i]);
            y = (p_m[i] != 0) ? sval(p_b[i], wdt[i]) : int'(p_b[i]);
            m_lt[i] = (x < y) ? 1 : 0;
            m_gt[i] = (x > y) ? 1 : 0;
            m_eq[i] = (x == y) ? 1 : 0;
            m_sym[i] = (x > y) ? 10 : ((x < y) ? 11 : 14);
            m_rv[i] = 1;
            if (in_clr[i] == 1'b0) begin
                if (x > y && m_gc[i] < cmax[i]) m_gc[i]++;
                if (x < y && m_lc[i] < cmax[i]) m_lc[i]++;
                if (x == y && m_ec[i] < cmax[i]) m_ec[i]++;
            end
        end else begin
            m_rv[i] = 0;
        end
        if (in_clr[i] == 1'b1) begin
            m_gc[i] = 0; m_lc[i] = 0; m_ec[i] = 0;
        end
        if (in_load[i] == 1'b1) begin
            m_aq[i] = in_a[i]; m_bq[i] = in_b[i];
            p_a[i] = in_a[i]; p_b[i] = in_b[i]; p_m[i] = int'(in_mode[i]); p_v[i] = 1;
        end else begin
            p_v[i] = 0;
        end
    endtask

    task automatic check_inst(input int i, input logic [15:0] aq, input logic [15:0] bq,
                              input logic l, input logic g, input logic e,
                              input logic [3:0] s, input logic rv,
                              input logic [7:0] gc, input logic [7:0] lc, input logic [7:0] ec);
        string p;
        p = $sformatf("u%0d", i);
        chk({p, " a_q"}, 32'(aq), 32'(m_aq[i]));
        chk({p, " b_q"}, 32'(bq), 32'(m_bq[i]));
        chk({p, " lt"}, 32'(l), 32'(m_lt[i]));
        chk({p, " gt"}, 32'(g), 32'(m_gt[i]));
        chk({p, " eq"}, 32'(e), 32'(m_eq[i]));
        chk({p, " sym"}, 32'(s), 32'(m_sym[i]));
        chk({p, " result_valid"}, 32'(rv), 32'(m_rv[i]));
        chk({p, " gt_cnt"}, 32'(gc), 32'(m_gc[i]));
        chk({p, " lt_cnt"}, 32'(lc), 32'(m_lc[i]));
        chk({p, " eq_cnt"}, 32'(ec), 32'(m_ec[i]));
    endtask

    task automatic check_all();
        check_inst(0, {12'h000, aq0}, {12'h000, bq0}, lt0, gt0, eq0, sym0, rv0,
                   {6'h00, gc0}, {6'h00, lc0}, {6'h00, ec0});
        check_inst(1, aq1, bq1, lt1, gt1, eq1, sym1, rv1, gc1, lc1, ec1);
    endtask

    // one clock edge: advance the model with the sampled inputs, then check
    task automatic tick();
        @(posedge clk);
        if (rst == 1'b0) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_all();
    endtask

    // asynchronous reset asserted mid-cycle, held across one edge
    task automatic mid_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_in(input int i, input logic [15:0] va, input logic [15:0] vb,
                          input logic ld, input logic md, input logic cl);
        in_a[i] = va; in_b[i] = vb; in_load[i] = ld; in_mode[i] = md; in_clr[i] = cl;
    endtask

    initial begin
        logic [15:0] mask, ra, rb;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) set_in(i, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // unsigned 4-bit: 9>3, 3<9, 5==5 back to back
        set_in(0, 16'd9, 16'd3, 1'b1, 1'b0, 1'b0); tick();
        set_in(0, 16'd3, 16'd9, 1'b1, 1'b0, 1'b0); tick();
        chk("uns first sym", 32'(sym0), 32'hA);
        set_in(0, 16'd5, 16'd5, 1'b1, 1'b0, 1'b0); tick();
        chk("uns second sym", 32'(sym0), 32'hB);
        set_in(0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0); tick();
        chk("uns third sym", 32'(sym0), 32'hE);
        chk("uns third rv", 32'(rv0), 32'h1);
        chk("uns gt_cnt", 32'(gc0), 32'h1);
        chk("uns lt_cnt", 32'(lc0), 32'h1);
        chk("uns eq_cnt", 32'(ec0), 32'h1);
        tick();
        chk("uns drained rv", 32'(rv0), 32'h0);
        chk("uns held sym", 32'(sym0), 32'hE);

        // signed vs unsigned view of 4'hF against 4'h1
        set_in(0, 16'hF, 16'h1, 1'b1, 1'b1, 1'b0); tick();
        set_in(0, 16'hF, 16'h1, 1'b1, 1'b0, 1'b0); tick();
        chk("signed lt", 32'(lt0), 32'h1);
        chk("signed sym", 32'(sym0), 32'hB);
        set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); tick();
        chk("unsigned gt", 32'(gt0), 32'h1);
        chk("unsigned sym", 32'(sym0), 32'hA);

        // saturation of the 2-bit gt tally
        set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
        for (int k = 0; k < 6; k++) begin
            set_in(0, 16'd7, 16'd2, 1'b1, 1'b0, 1'b0); tick();
        end
        set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); tick(); tick();
        chk("sat gt_cnt", 32'(gc0), 32'h3);
        chk("sat lt_cnt", 32'(lc0), 32'h0);
        chk("sat eq_cnt", 32'(ec0), 32'h0);

        // clear landing on the same edge as a gt result
        set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
        set_in(0, 16'd6, 16'd1, 1'b1, 1'b0, 1'b0); tick(); tick();
        set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); tick();
        chk("pre-clear gt_cnt", 32'(gc0), 32'h2);
        set_in(0, 16'd6, 16'd1, 1'b1, 1'b0, 1'b0); tick();
        set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1); tick();
        chk("collide gt_cnt", 32'(gc0), 32'h0);
        chk("collide gt", 32'(gt0), 32'h1);
        chk("collide sym", 32'(sym0), 32'hA);
        chk("collide rv", 32'(rv0), 32'h1);
        set_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); tick();

        // 16-bit signed corner cases
        set_in(1, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0); tick();
        set_in(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0); tick();
        chk("wide lt", 32'(lt1), 32'h1);
        set_in(1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0); tick();
        chk("wide eq", 32'(eq1), 32'h1);
        chk("wide eq_cnt", 32'(ec1), 32'h1);

        // reset mid-stream with load held high
        set_in(0, 16'd3, 16'd4, 1'b1, 1'b0, 1'b0);
        set_in(1, 16'd9, 16'd2, 1'b1, 1'b0, 1'b0);
        tick();
        mid_reset();
        chk("reset sym", 32'(sym0), 32'hF);
        tick();
        chk("no stray rv", 32'(rv0), 32'h0);
        tick();

        // randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                mask = (i == 0) ? 16'h000F : 16'hFFFF;
                ra = 16'($urandom) & mask;
                rb = 16'($urandom) & mask;
                if ($urandom_range(0, 4) == 0) rb = ra;
                set_in(i, ra, rb, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 24) == 0));
            end
            if ((c % 151) == 77) mid_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
